// File: rtl/enc_arbiter_8.sv
// Eight-requester arbiter with registered one-hot grant and encoded index.
// Round-robin or fixed-priority selection, a bounded tenure and a one-cycle gap between grants.
module enc_arbiter_8 #(
  parameter int RR       = 1,
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] y,
  output logic       v,
  output logic       timeout
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  localparam logic [7:0] LP_MAX_HOLD = 8'(MAX_HOLD);

  state_t     r_state, w_state_next;
  logic [7:0] r_gnt, w_gnt_next;
  logic [7:0] r_cnt, w_cnt_next;
  logic [2:0] r_y, w_y_next;
  logic [2:0] r_last, w_last_next;
  logic       r_v, w_v_next;
  logic       r_timeout, w_timeout_next;
  logic [2:0] w_win;
  logic [2:0] w_idx;
  logic       w_any;

  assign w_any = |req;

  // Scanning from the far end and overwriting leaves the nearest hit in w_win.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    if (RR != 0) begin
      for (int d = 8; d >= 1; d--) begin
        w_idx = r_last + 3'(d);
        if (req[w_idx]) w_win = w_idx;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (req[i]) w_win = 3'(i);
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_gnt_next     = r_gnt;
    w_cnt_next     = r_cnt;
    w_y_next       = r_y;
    w_last_next    = r_last;
    w_v_next       = r_v;
    w_timeout_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gnt_next = '0;
        w_v_next   = 1'b0;
        if (en && w_any) begin
          w_gnt_next   = 8'b1 << w_win;
          w_y_next     = w_win;
          w_v_next     = 1'b1;
          w_cnt_next   = 8'd1;
          w_state_next = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!en || !req[r_y]) begin
          w_gnt_next   = '0;
          w_v_next     = 1'b0;
          w_state_next = S_GAP;
        end else if ((MAX_HOLD != 0) && (r_cnt == LP_MAX_HOLD)) begin
          w_gnt_next     = '0;
          w_v_next       = 1'b0;
          w_timeout_next = 1'b1;
          w_state_next   = S_GAP;
        end else if (r_cnt != 8'hFF) begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_GAP: begin
        w_gnt_next   = '0;
        w_v_next     = 1'b0;
        w_last_next  = r_y;
        w_state_next = S_IDLE;
      end
      default: begin
        w_gnt_next   = '0;
        w_v_next     = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_cnt     <= '0;
      r_y       <= '0;
      r_last    <= 3'd7;
      r_v       <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_gnt     <= w_gnt_next;
      r_cnt     <= w_cnt_next;
      r_y       <= w_y_next;
      r_last    <= w_last_next;
      r_v       <= w_v_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign gnt     = r_gnt;
  assign y       = r_y;
  assign v       = r_v;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_enc_arbiter_8.sv
// Bench for enc_arbiter_8: three configurations driven in parallel and compared each cycle
// against a behavioural model, plus a vector table and directed corner sequences.
module tb_enc_arbiter_8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] req = 8'h00;

  logic [7:0] d_gnt[3];
  logic [2:0] d_y[3];
  logic       d_v[3];
  logic       d_to[3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // 0: round-robin, hold 4; 1: fixed priority, hold 15; 2: round-robin, unlimited
  enc_arbiter_8 #(.RR(1), .MAX_HOLD(4)) u_rr4 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(d_gnt[0]), .y(d_y[0]), .v(d_v[0]), .timeout(d_to[0]));
  enc_arbiter_8 #(.RR(0), .MAX_HOLD(15)) u_fix (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(d_gnt[1]), .y(d_y[1]), .v(d_v[1]), .timeout(d_to[1]));
  enc_arbiter_8 #(.RR(1), .MAX_HOLD(0)) u_rr0 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(d_gnt[2]), .y(d_y[2]), .v(d_v[2]), .timeout(d_to[2]));

  // Reference model: phase 0 = idle, 1 = granted, 2 = gap
  int         m_phase[3];
  int         m_owner[3];
  int         m_held[3];
  int         m_last[3];
  logic [7:0] m_gnt[3];
  logic [2:0] m_y[3];
  logic       m_to[3];

  function automatic int rr_of(input int k);
    return (k == 1) ? 0 : 1;
  endfunction

  function automatic int mh_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 15 : 0);
  endfunction

  function automatic int pick(input int k, input logic [7:0] r);
    if (rr_of(k) != 0) begin
      for (int d = 1; d <= 8; d++) begin
        if (r[(m_last[k] + d) % 8]) return (m_last[k] + d) % 8;
      end
    end else begin
      for (int j = 7; j >= 0; j--) begin
        if (r[j]) return j;
      end
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_phase[k] = 0; m_owner[k] = 0; m_held[k] = 0; m_last[k] = 7;
      m_gnt[k] = 8'h00; m_y[k] = 3'd0; m_to[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int w;
    for (int k = 0; k < 3; k++) begin
      m_to[k] = 1'b0;
      case (m_phase[k])
        0: begin
          w = pick(k, req);
          if (en && w >= 0) begin
            m_owner[k] = w; m_y[k] = 3'(w); m_gnt[k] = 8'h01 << w;
            m_held[k] = 1; m_phase[k] = 1;
          end else begin
            m_gnt[k] = 8'h00;
          end
        end
        1: begin
          if (!en || !req[m_owner[k]]) begin
            m_gnt[k] = 8'h00; m_phase[k] = 2;
          end else if (mh_of(k) != 0 && m_held[k] == mh_of(k)) begin
            m_gnt[k] = 8'h00; m_to[k] = 1'b1; m_phase[k] = 2;
          end else if (m_held[k] < 255) begin
            m_held[k]++;
          end
        end
        default: begin
          m_last[k] = m_owner[k]; m_phase[k] = 0;
        end
      endcase
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d {gnt,y,v,to}", k),
          32'({d_gnt[k], d_y[k], d_v[k], d_to[k]}),
          32'({m_gnt[k], m_y[k], (m_gnt[k] != 8'h00), m_to[k]}));
      chk($sformatf("dut%0d onehot/v", k),
          32'($onehot0(d_gnt[k]) && (d_v[k] == (|d_gnt[k]))), 32'd1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] y;
    logic       to;
  } vec_t;

  vec_t tbl[10];
  int   starts[4];
  int   lens[4];
  int   n_start;
  int   hi;
  int   to_cnt;
  logic [7:0] prev;

  initial begin
    // fixed-priority instance, starting from idle just after reset
    tbl[0] = '{1'b1, 8'h2C, 8'h20, 3'd5, 1'b0};
    tbl[1] = '{1'b1, 8'h2C, 8'h20, 3'd5, 1'b0};
    tbl[2] = '{1'b1, 8'h0C, 8'h00, 3'd5, 1'b0};
    tbl[3] = '{1'b1, 8'h0C, 8'h00, 3'd5, 1'b0};
    tbl[4] = '{1'b1, 8'h0C, 8'h08, 3'd3, 1'b0};
    tbl[5] = '{1'b1, 8'h0C, 8'h08, 3'd3, 1'b0};
    tbl[6] = '{1'b0, 8'h0C, 8'h00, 3'd3, 1'b0};
    tbl[7] = '{1'b0, 8'hFF, 8'h00, 3'd3, 1'b0};
    tbl[8] = '{1'b0, 8'hFF, 8'h00, 3'd3, 1'b0};
    tbl[9] = '{1'b1, 8'hFF, 8'h80, 3'd7, 1'b0};

    // held in reset with every request active
    model_reset();
    rst = 1'b1; en = 1'b1; req = 8'hFF;
    repeat (3) step();
    chk("in-reset gnt", 32'(d_gnt[0]), 32'h0);
    chk("in-reset v", 32'(d_v[0]), 32'h0);
    chk("in-reset y", 32'(d_y[0]), 32'h0);
    rst = 1'b0;
    step();
    chk("first rr gnt", 32'(d_gnt[0]), 32'h01);
    chk("first rr y", 32'(d_y[0]), 32'h0);
    chk("first rr v", 32'(d_v[0]), 32'h1);
    chk("first fixed gnt", 32'(d_gnt[1]), 32'h80);

    // round-robin rotation with MAX_HOLD=4
    do_reset();
    req = 8'h92; en = 1'b1;
    n_start = 0; hi = 0; prev = 8'h00;
    for (int i = 0; i < 4; i++) begin starts[i] = -1; lens[i] = -1; end
    repeat (24) begin
      step();
      if (prev == 8'h00 && d_gnt[0] != 8'h00 && n_start < 4) begin
        starts[n_start] = int'(d_y[0]);
        n_start++;
        hi = 0;
      end
      if (d_gnt[0] != 8'h00) hi++;
      if (prev != 8'h00 && d_gnt[0] == 8'h00) begin
        chk("rr4 timeout on fall", 32'(d_to[0]), 32'h1);
        if (n_start >= 1) lens[n_start-1] = hi;
      end
      prev = d_gnt[0];
    end
    chk("rr4 grant 0", 32'(starts[0]), 32'd1);
    chk("rr4 grant 1", 32'(starts[1]), 32'd4);
    chk("rr4 grant 2", 32'(starts[2]), 32'd7);
    chk("rr4 grant 3", 32'(starts[3]), 32'd1);
    for (int i = 0; i < 4; i++) chk($sformatf("rr4 tenure %0d len", i), 32'(lens[i]), 32'd4);

    // fixed-priority vector table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      en = tbl[i].en; req = tbl[i].req;
      step();
      chk($sformatf("tbl%0d gnt", i), 32'(d_gnt[1]), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d y", i), 32'(d_y[1]), 32'(tbl[i].y));
      chk($sformatf("tbl%0d v", i), 32'(d_v[1]), 32'(tbl[i].gnt != 8'h00));
      chk($sformatf("tbl%0d to", i), 32'(d_to[1]), 32'(tbl[i].to));
    end

    // unlimited tenure held for 300 cycles
    do_reset();
    en = 1'b1; req = 8'h08;
    step();
    to_cnt = 0;
    repeat (300) begin
      step();
      if (d_to[2]) to_cnt++;
    end
    chk("rr0 no timeout", 32'(to_cnt), 32'd0);
    chk("rr0 still held", 32'(d_gnt[2]), 32'h08);
    req = 8'h00;
    step();
    chk("rr0 release", 32'(d_gnt[2]), 32'h00);

    // asynchronous reset between edges mid-tenure
    req = 8'hFF;
    repeat (3) step();
    chk("pre-rst granted", 32'(d_v[0]), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++)
      chk($sformatf("async rst dut%0d", k), 32'({d_gnt[k], d_y[k], d_v[k], d_to[k]}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post-rst rr gnt", 32'(d_gnt[0]), 32'h01);
    chk("post-rst fixed gnt", 32'(d_gnt[1]), 32'h80);

    // random traffic against the model
    repeat (500) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      en = ($urandom_range(0, 7) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
